contador_param: RTL and testbench



---
 rtl/contador_param.sv | 88 ++++++++
 tb/tb_contador_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
// Parametrised up/down/down-by-STEP/load counter with cascade enable (CIN) and
// terminal-count look-ahead (TC). Define CONTADOR_SATURATE_EN to saturate instead of wrapping.
module contador_param #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic             CIN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TC
);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_STEP = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             rco_reg;
    logic             rco_next;
    logic             wrap;
    logic             count_en;

    // Wrap condition for the current mode, evaluated on the present count.
    always_comb begin
        wrap = 1'b0;
        case (MODO)
            MODO_UP:   wrap = (q_reg == {WIDTH{1'b1}});
            MODO_DOWN: wrap = (q_reg == '0);
            MODO_STEP: wrap = (q_reg < STEP_W);
            default:   wrap = 1'b0;
        endcase
    end

    assign count_en = ENB & CIN & (MODO != MODO_LOAD);

    always_comb begin
        q_next   = q_reg;
        rco_next = 1'b0;
        if (ENB) begin
            if (MODO == MODO_LOAD) begin
                q_next = D;
            end else if (CIN) begin
                rco_next = wrap;
`ifdef CONTADOR_SATURATE_EN
                // Saturating build: boundary is held, RCO still flags each overflow attempt.
                case (MODO)
                    MODO_UP:   q_next = wrap ? q_reg : q_reg + 1'b1;
                    MODO_DOWN: q_next = wrap ? '0 : q_reg - 1'b1;
                    MODO_STEP: q_next = wrap ? '0 : q_reg - STEP_W;
                    default:   q_next = q_reg;
                endcase
`else
                case (MODO)
                    MODO_UP:   q_next = q_reg + 1'b1;
                    MODO_DOWN: q_next = q_reg - 1'b1;
                    MODO_STEP: q_next = q_reg - STEP_W;
                    default:   q_next = q_reg;
                endcase
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_reg   <= '0;
            rco_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            rco_reg <= rco_next;
        end
    end

    assign Q   = q_reg;
    assign RCO = rco_reg;
    // Look-ahead is suppressed during reset so a cascade never sees a spurious carry.
    assign TC  = count_en & wrap & ~RESET;

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: two 8-bit stages chained TC->CIN, STEP=3.
module tb_contador_param;

    logic       clk;
    logic       srst;
    logic       enb;
    logic       cin_lo;
    logic [1:0] modo;
    logic [7:0] d_lo;
    logic [7:0] d_hi;
    logic [7:0] q_lo;
    logic [7:0] q_hi;
    logic       rco_lo;
    logic       rco_hi;
    logic       tc_lo;
    logic       tc_hi;

    int n_checks;
    int n_fail;

    contador_param #(.WIDTH(8), .STEP(3)) u_lo (
        .CLK  (clk),
        .RESET(srst),
        .ENB  (enb),
        .CIN  (cin_lo),
        .MODO (modo),
        .D    (d_lo),
        .Q    (q_lo),
        .RCO  (rco_lo),
        .TC   (tc_lo)
    );

    contador_param #(.WIDTH(8), .STEP(3)) u_hi (
        .CLK  (clk),
        .RESET(srst),
        .ENB  (enb),
        .CIN  (tc_lo),
        .MODO (modo),
        .D    (d_hi),
        .Q    (q_hi),
        .RCO  (rco_hi),
        .TC   (tc_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

`ifdef CONTADOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        srst   = 1'b1;
        enb    = 1'b1;
        cin_lo = 1'b1;
        modo   = 2'b00;
        d_lo   = 8'h00;
        d_hi   = 8'h00;

        // Reset for two edges
        step(2);
        check("rst_q", {24'h0, q_lo}, 32'h00);
        check("rst_rco", {31'h0, rco_lo}, 32'h0);
        check("rst_tc", {31'h0, tc_lo}, 32'h0);
        check("rst_qhi", {24'h0, q_hi}, 32'h00);
        // Down mode at Q=0 would wrap, but TC must stay low under reset
        modo = 2'b01;
        #1;
        check("rst_tc_dn", {31'h0, tc_lo}, 32'h0);
        modo = 2'b00;

        // 255 up edges
        srst = 1'b0;
        step(255);
        check("up255_q", {24'h0, q_lo}, 32'hFF);
        check("up255_tc", {31'h0, tc_lo}, 32'h1);
        check("up255_rco", {31'h0, rco_lo}, 32'h0);
        check("up255_qhi", {24'h0, q_hi}, 32'h00);
        step(1);
        check("upwrap_q", {24'h0, q_lo}, SAT ? 32'hFF : 32'h00);
        check("upwrap_rco", {31'h0, rco_lo}, 32'h1);
        check("upwrap_qhi", {24'h0, q_hi}, 32'h01);
        step(1);
        check("upnext_q", {24'h0, q_lo}, SAT ? 32'hFF : 32'h01);
        check("upnext_rco", {31'h0, rco_lo}, SAT ? 32'h1 : 32'h0);

        // Load with CIN=0, then count down 3
        modo = 2'b11; d_lo = 8'hA5; d_hi = 8'h00; cin_lo = 1'b0;
        step(1);
        check("load_q", {24'h0, q_lo}, 32'hA5);
        check("load_rco", {31'h0, rco_lo}, 32'h0);
        modo = 2'b01; cin_lo = 1'b1;
        step(3);
        check("dn3_q", {24'h0, q_lo}, 32'hA2);
        // CIN=0 holds in a counting mode
        cin_lo = 1'b0; modo = 2'b00;
        step(2);
        check("cin0_q", {24'h0, q_lo}, 32'hA2);
        check("cin0_rco", {31'h0, rco_lo}, 32'h0);
        cin_lo = 1'b1;

        // Down by STEP
        modo = 2'b11; d_lo = 8'h04;
        step(1);
        modo = 2'b10;
        step(1);
        check("stp_q", {24'h0, q_lo}, 32'h01);
        check("stp_tc", {31'h0, tc_lo}, 32'h1);
        check("stp_rco", {31'h0, rco_lo}, 32'h0);
        step(1);
        check("stpwrap_q", {24'h0, q_lo}, SAT ? 32'h00 : 32'hFE);
        check("stpwrap_rco", {31'h0, rco_lo}, 32'h1);

        // 16-bit cascade 0x00FF -> 0x0100
        modo = 2'b11; d_lo = 8'hFF; d_hi = 8'h00;
        step(1);
        modo = 2'b00;
        #1;
        check("cas_tclo", {31'h0, tc_lo}, 32'h1);
        check("cas_tchi", {31'h0, tc_hi}, 32'h0);
        step(1);
        check("cas_q16", {16'h0, q_hi, q_lo}, SAT ? 32'h01FF : 32'h0100);
        check("cas_rcolo", {31'h0, rco_lo}, 32'h1);
        check("cas_rcohi", {31'h0, rco_hi}, 32'h0);

        // Reset mid-count
        modo = 2'b11; d_lo = 8'h7E;
        step(1);
        modo = 2'b00;
        step(1);
        check("pre_rst_q", {24'h0, q_lo}, 32'h7F);
        srst = 1'b1;
        step(1);
        check("midrst_q", {24'h0, q_lo}, 32'h00);
        check("midrst_rco", {31'h0, rco_lo}, 32'h0);
        srst = 1'b0;

        // ENB=0 hold for 5 edges on a non-zero value
        modo = 2'b11; d_lo = 8'h33;
        step(1);
        enb = 1'b0; modo = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("hold%0d_q", i), {24'h0, q_lo}, 32'h33);
            check($sformatf("hold%0d_rco", i), {31'h0, rco_lo}, 32'h0);
        end
        check("hold_tc", {31'h0, tc_lo}, 32'h0);

        // Down wrap from 0, then ENB=0 clears RCO
        enb = 1'b1; modo = 2'b11; d_lo = 8'h00;
        step(1);
        modo = 2'b01;
        #1;
        check("dnw_tc", {31'h0, tc_lo}, 32'h1);
        step(1);
        check("dnw_q", {24'h0, q_lo}, SAT ? 32'h00 : 32'hFF);
        check("dnw_rco", {31'h0, rco_lo}, 32'h1);
        enb = 1'b0;
        step(1);
        check("dnw_hold_q", {24'h0, q_lo}, SAT ? 32'h00 : 32'hFF);
        check("dnw_hold_rco", {31'h0, rco_lo}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
